// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-control bundle between the CPU datapath (master) and the hazard
// controller (slave): hazard/memory events in, stage enables and flushes out.
interface pipe_hazard_ctrl_if;
  logic [3:0]  id_rs1;
  logic [3:0]  id_rs2;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic [3:0]  ex_rd;
  logic        ex_mem_read;
  logic        ex_branch_taken;
  logic        mem_access;
  logic        dmem_ready;

  logic        dmem_req;
  logic        pc_en;
  logic        if_id_en;
  logic        id_ex_en;
  logic        ex_mem_en;
  logic        mem_wb_en;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        mem_wb_flush;
  logic        mem_timeout;
  logic [15:0] stall_count;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, mem_access, dmem_ready,
    input  dmem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, mem_wb_flush, mem_timeout, stall_count
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, mem_access, dmem_ready,
    output dmem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, mem_wb_flush, mem_timeout, stall_count
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline sequencer: memory wait/timeout FSM, branch flush and
// load-use bubble arbitration, sticky timeout flag and saturating stall counter.
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 8
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave bus
);
  typedef enum logic {M_IDLE, M_WAIT} mstate_e;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  mstate_e     state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        mem_timeout_q, mem_timeout_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic mem_stall, mem_abort, load_use;

  always_comb begin
    mem_stall     = 1'b0;
    mem_abort     = 1'b0;
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    case (state_q)
      M_IDLE: begin
        if (bus.mem_access && !bus.dmem_ready) begin
          mem_stall  = 1'b1;
          state_d    = M_WAIT;
          wait_cnt_d = '0;
        end
      end
      M_WAIT: begin
        if (bus.dmem_ready) begin
          state_d = M_IDLE;
        end else if (wait_cnt_q < WAIT_LAST) begin
          mem_stall  = 1'b1;
          wait_cnt_d = wait_cnt_q + 8'd1;
        end else begin
          // abort: release the pipe but squash the write-back of the dead access
          mem_abort     = 1'b1;
          state_d       = M_IDLE;
          mem_timeout_d = 1'b1;
        end
      end
      default: state_d = M_IDLE;
    endcase
  end

  assign load_use = bus.ex_mem_read && (bus.ex_rd != 4'd0) &&
                    ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                     (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));

  always_comb begin
    bus.dmem_req     = (state_q == M_WAIT) || bus.mem_access;
    bus.pc_en        = 1'b1;
    bus.if_id_en     = 1'b1;
    bus.id_ex_en     = 1'b1;
    bus.ex_mem_en    = 1'b1;
    bus.mem_wb_en    = 1'b1;
    bus.if_id_flush  = 1'b0;
    bus.id_ex_flush  = 1'b0;
    bus.mem_wb_flush = 1'b0;
    // a frozen front end holds any branch / load-use until the stall releases
    if (mem_stall) begin
      bus.pc_en        = 1'b0;
      bus.if_id_en     = 1'b0;
      bus.id_ex_en     = 1'b0;
      bus.ex_mem_en    = 1'b0;
      bus.mem_wb_flush = 1'b1;
    end else if (bus.ex_branch_taken) begin
      bus.if_id_flush = 1'b1;
      bus.id_ex_flush = 1'b1;
    end else if (load_use) begin
      bus.pc_en       = 1'b0;
      bus.if_id_en    = 1'b0;
      bus.id_ex_flush = 1'b1;
    end
    if (mem_abort) bus.mem_wb_flush = 1'b1;
    if (rst) begin
      bus.dmem_req     = 1'b0;
      bus.pc_en        = 1'b0;
      bus.if_id_en     = 1'b0;
      bus.id_ex_en     = 1'b0;
      bus.ex_mem_en    = 1'b0;
      bus.mem_wb_en    = 1'b0;
      bus.if_id_flush  = 1'b0;
      bus.id_ex_flush  = 1'b0;
      bus.mem_wb_flush = 1'b0;
    end
  end

  assign stall_cnt_d = (!bus.pc_en && (stall_cnt_q != 16'hFFFF)) ?
                       stall_cnt_q + 16'd1 : stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= M_IDLE;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign bus.mem_timeout = mem_timeout_q;
  assign bus.stall_count = stall_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: per-cycle expected controls pushed at
// drive time, popped and compared mid-cycle against the DUT.
module tb_pipe_hazard_ctrl;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if bus ();
  pipe_hazard_ctrl #(.TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic       r;
    logic [3:0] rs1, rs2;
    logic       u1, u2;
    logic [3:0] rd;
    logic       mr, br, macc, rdy;
  } stim_t;

  // ctl = {req, pc, if_id, id_ex, ex_mem, mem_wb, f_if_id, f_id_ex, f_mem_wb}
  typedef struct packed {
    logic [8:0]  ctl;
    logic        to;
    logic [15:0] sc;
  } exp_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  bit m_wait;
  int m_cnt;
  bit m_to;
  int m_sc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t predict(input stim_t s);
    exp_t e;
    bit stall, abort, lu;
    bit pc, ifid, idex, exmem, memwb, fif, fid, fmw;
    stall = (!m_wait && s.macc && !s.rdy) || (m_wait && !s.rdy && m_cnt < TO - 1);
    abort = m_wait && !s.rdy && m_cnt == TO - 1;
    lu = s.mr && s.rd != 4'd0 && ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
    {pc, ifid, idex, exmem, memwb} = 5'b11111;
    {fif, fid, fmw} = 3'b000;
    if (stall) begin
      {pc, ifid, idex, exmem} = 4'b0000;
      fmw = 1'b1;
    end else if (s.br) begin
      fif = 1'b1;
      fid = 1'b1;
    end else if (lu) begin
      pc   = 1'b0;
      ifid = 1'b0;
      fid  = 1'b1;
    end
    if (abort) fmw = 1'b1;
    e.ctl = {m_wait || s.macc, pc, ifid, idex, exmem, memwb, fif, fid, fmw};
    if (s.r) e.ctl = '0;
    e.to = m_to;
    e.sc = 16'(m_sc);
    return e;
  endfunction

  task automatic step(input stim_t s);
    exp_t e;
    rst                 = s.r;
    bus.id_rs1          = s.rs1;
    bus.id_rs2          = s.rs2;
    bus.id_use_rs1      = s.u1;
    bus.id_use_rs2      = s.u2;
    bus.ex_rd           = s.rd;
    bus.ex_mem_read     = s.mr;
    bus.ex_branch_taken = s.br;
    bus.mem_access      = s.macc;
    bus.dmem_ready      = s.rdy;
    sb.push_back(predict(s));
    @(negedge clk);
    e = sb.pop_front();
    chk("ctl", 32'({bus.dmem_req, bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en,
                    bus.mem_wb_en, bus.if_id_flush, bus.id_ex_flush, bus.mem_wb_flush}),
        32'(e.ctl));
    chk("mem_timeout", 32'(bus.mem_timeout), 32'(e.to));
    chk("stall_count", 32'(bus.stall_count), 32'(e.sc));
    if (s.r) begin
      m_wait = 0; m_cnt = 0; m_to = 0; m_sc = 0;
    end else begin
      if (!e.ctl[7] && m_sc < 65535) m_sc++;
      if (!m_wait) begin
        if (s.macc && !s.rdy) begin m_wait = 1; m_cnt = 0; end
      end else if (s.rdy) m_wait = 0;
      else if (m_cnt < TO - 1) m_cnt++;
      else begin m_wait = 0; m_to = 1; end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step_m(input bit macc, input bit rdy, input bit br);
    stim_t s = '0;
    s.macc = macc; s.rdy = rdy; s.br = br;
    step(s);
  endtask

  task automatic step_h(input bit mr, input logic [3:0] rd, input logic [3:0] rs1,
                        input logic [3:0] rs2, input bit u1, input bit u2, input bit br);
    stim_t s = '0;
    s.mr = mr; s.rd = rd; s.rs1 = rs1; s.rs2 = rs2; s.u1 = u1; s.u2 = u2; s.br = br;
    step(s);
  endtask

  task automatic step_r(input bit macc);
    stim_t s = '0;
    s.r = 1'b1; s.macc = macc;
    step(s);
  endtask

  initial begin
    stim_t s;
    m_wait = 0; m_cnt = 0; m_to = 0; m_sc = 0;
    step_r(0);
    step_r(1);

    step_m(0, 0, 0);
    step_m(1, 1, 0);                       // zero-wait store
    chk("zw_stall_count", 32'(bus.stall_count), 32'd0);

    repeat (3) step_m(1, 0, 0);            // 3-wait load
    step_m(1, 1, 0);
    step_m(0, 0, 0);
    chk("w3_stall_count", 32'(bus.stall_count), 32'd3);

    step_r(0);                             // ready in the would-be abort cycle
    repeat (TO) step_m(1, 0, 0);
    step_m(1, 1, 0);
    step_m(0, 0, 0);
    chk("late_rdy_timeout", 32'(bus.mem_timeout), 32'd0);

    step_r(0);                             // unanswered access
    repeat (TO) step_m(1, 0, 0);
    step_m(1, 0, 0);
    step_m(0, 0, 0);
    chk("to_flag", 32'(bus.mem_timeout), 32'd1);
    chk("to_stall_count", 32'(bus.stall_count), 32'(TO));

    step_h(1, 5, 0, 5, 0, 1, 0);           // load-use bubble, then clear
    step_h(0, 5, 0, 5, 0, 1, 0);
    step_h(1, 0, 0, 0, 0, 1, 0);
    step_h(1, 5, 0, 5, 0, 0, 0);
    step_h(1, 7, 7, 0, 1, 0, 0);
    step_h(1, 5, 0, 5, 0, 1, 1);           // branch beats load-use

    step_m(1, 0, 1);                       // branch held through a memory stall
    step_m(1, 0, 1);
    step_m(1, 1, 1);
    step_m(0, 0, 0);

    repeat (TO) step_m(1, 0, 1);           // abort cycle combined with branch
    step_m(1, 0, 1);
    step_m(0, 0, 0);

    step_m(1, 0, 0);                       // reset while waiting
    step_m(1, 0, 0);
    step_r(1);
    step_m(0, 0, 0);
    chk("rst_timeout", 32'(bus.mem_timeout), 32'd0);
    chk("rst_stall_count", 32'(bus.stall_count), 32'd0);

    for (int i = 0; i < 400; i++) begin
      s.r    = ($urandom_range(0, 49) == 0);
      s.rs1  = 4'($urandom_range(0, 3));
      s.rs2  = 4'($urandom_range(0, 3));
      s.u1   = 1'($urandom_range(0, 1));
      s.u2   = 1'($urandom_range(0, 1));
      s.rd   = 4'($urandom_range(0, 3));
      s.mr   = 1'($urandom_range(0, 1));
      s.br   = ($urandom_range(0, 3) == 0);
      s.macc = 1'($urandom_range(0, 1));
      s.rdy  = ($urandom_range(0, 3) == 0);
      step(s);
    end

    step_r(0);
    repeat (65540) step_h(1, 5, 0, 5, 0, 1, 0);
    chk("sat_stall_count", 32'(bus.stall_count), 32'h0000FFFF);
    step_h(1, 5, 0, 5, 0, 1, 0);
    chk("sat_hold", 32'(bus.stall_count), 32'h0000FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
